// File: rtl/serial_detector_controller.sv
// serial_detector_controller: serialises words MSB-first into an external Moore detector and counts its hits per word
//   clk, rst_n (async, active-low)
//   in_valid/in_ready/in_data/in_restart : upstream word handshake, restart clears the detector first
//   det_j/det_en/det_clr/det_w           : detector drive (bit, advance, clear) and its Moore output
//   out_valid/out_ready/out_count/out_hit: per-word result handshake
module serial_detector_controller #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_restart,
  output logic             det_j,
  output logic             det_en,
  output logic             det_clr,
  input  logic             det_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_hit
);
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] det_cnt;
  logic en_d;
  assign det_j = sr[WIDTH-1] & det_en;
  // the running count is only exposed while a result is being offered
  assign out_count = out_valid ? det_cnt : '0;
  assign out_hit = out_valid & (|det_cnt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      det_cnt <= '0;
      en_d <= 1'b0;
      in_ready <= 1'b1;
      det_en <= 1'b0;
      det_clr <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // det_w answers the bit enabled one cycle earlier, so qualify it with the delayed enable
      en_d <= det_en;
      if (en_d && det_w && det_cnt != CW'(WIDTH)) det_cnt <= det_cnt + 1'b1;
      case (state)
        IDLE: if (in_valid) begin
          sr <= in_data;
          bit_cnt <= '0;
          det_cnt <= '0;
          in_ready <= 1'b0;
          det_clr <= in_restart;
          det_en <= !in_restart;
          state <= in_restart ? CLR : SHIFT;
        end
        CLR: begin
          det_clr <= 1'b0;
          det_en <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          sr <= {sr[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            det_en <= 1'b0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_detector_controller.sv
// tb_serial_detector_controller: drives words through the controller into a behavioural 101 Moore detector
module tb_serial_detector_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = '0;
  logic in_restart = 1'b0;
  logic det_j, det_en, det_clr, det_w;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [3:0] out_count;
  logic out_hit;
  int checks = 0;
  int errors = 0;
  int q[$];
  int clr_cnt = 0;
  int j_cnt = 0;
  logic [7:0] j_log = '0;
  logic [1:0] ds;
  serial_detector_controller #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_restart(in_restart), .det_j(det_j), .det_en(det_en),
    .det_clr(det_clr), .det_w(det_w), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_hit(out_hit)
  );
  always #5 clk = ~clk;
  // overlapping 101 detector: 0=none, 1=seen 1, 2=seen 10, 3=seen 101
  assign det_w = (ds == 2'd3);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ds <= 2'd0;
    else if (det_clr) ds <= 2'd0;
    else if (det_en)
      case (ds)
        2'd0: ds <= det_j ? 2'd1 : 2'd0;
        2'd1: ds <= det_j ? 2'd1 : 2'd2;
        2'd2: ds <= det_j ? 2'd3 : 2'd0;
        default: ds <= det_j ? 2'd1 : 2'd2;
      endcase
  always @(posedge clk) begin
    if (det_en) begin
      j_log <= {j_log[6:0], det_j};
      j_cnt <= j_cnt + 1;
    end
    if (det_clr) clr_cnt <= clr_cnt + 1;
  end
  task automatic offer(input logic [7:0] d, input logic r);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_restart = r;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
  endtask
  // latency counts clock edges from the accept edge to the edge that first samples out_valid=1
  task automatic collect(input string name, input int exp_lat, input int hold);
    int lat = 1;
    int exp_cnt;
    logic [3:0] c0;
    @(negedge clk);
    if (hold == 0) in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp_cnt = (q.size() > 0) ? q.pop_front() : -1;
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (out_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_count: got %0d required %0d", name, out_count, exp_cnt);
    end
    checks++;
    if (out_hit !== (exp_cnt != 0)) begin
      errors++;
      $display("FAIL %s_hit: got %b required %b", name, out_hit, exp_cnt != 0);
    end
    c0 = out_count;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== c0) begin
        errors++;
        $display("FAIL %s_hold%0d: valid=%b ready=%b count=%0d required 1 0 %0d", name, i, out_valid, in_ready, out_count, c0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: valid=%b ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask
  task automatic check_reset_outputs(input string name);
    checks++;
    if ({in_ready, det_j, det_en, det_clr, out_valid, out_hit} !== 6'b100000 || out_count !== 4'd0) begin
      errors++;
      $display("FAIL %s: ready,j,en,clr,valid,hit=%b count=%0d required 100000 0", name, {in_ready, det_j, det_en, det_clr, out_valid, out_hit}, out_count);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    int c0 = clr_cnt;
    int j0 = j_cnt;
    q.push_back(3);
    offer(8'b10101010, 1'b1);
    collect("basic", 11, 0);
    checks++;
    if (clr_cnt - c0 != 1) begin
      errors++;
      $display("FAIL basic_clr: got %0d pulses required 1", clr_cnt - c0);
    end
    checks++;
    if (j_cnt - j0 != 8 || j_log !== 8'b10101010) begin
      errors++;
      $display("FAIL basic_bits: got %0d bits %b required 8 bits 10101010", j_cnt - j0, j_log);
    end
  endtask
  task automatic test_carry();
    int c0 = clr_cnt;
    q.push_back(1);
    offer(8'b10000000, 1'b0);
    collect("carry", 10, 0);
    checks++;
    if (clr_cnt != c0) begin
      errors++;
      $display("FAIL carry_clr: got %0d pulses required 0", clr_cnt - c0);
    end
  endtask
  task automatic test_cleared();
    q.push_back(0);
    offer(8'b10000000, 1'b1);
    collect("cleared", 11, 0);
  endtask
  task automatic test_backpressure();
    q.push_back(3);
    offer(8'b10101010, 1'b1);
    collect("hold", 11, 5);
  endtask
  task automatic test_abort();
    offer(8'b01011010, 1'b0);
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_valid%0d: got %b required 0", i, out_valid);
      end
    end
    rst_n = 1'b1;
    q.push_back(0);
    offer(8'b11111111, 1'b1);
    collect("after_abort", 11, 0);
  endtask
  task automatic test_pattern();
    q.push_back(3);
    offer(8'b10110101, 1'b1);
    collect("pattern", 11, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_cleared();
    test_backpressure();
    test_abort();
    test_pattern();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
